shift_register_universal: RTL and testbench
===========================================

// Module: shift_register_universal
// PURPOSE
//  Parametrised multi-mode shift register: WIDTH-bit parallel load, then a multi-cycle
//  shift of a requested amount, one bit per clock, under a start/busy/done handshake.
//  Modes: logical left, logical right, arithmetic right, optional rotate left.
//  Used in the datapath labs as the sequential shifter behind the ALU shift ops.
// PARAMETERS
//  WIDTH  128  data width in bits (>= 2)
//  AMT_W  8    width of the shift-amount port; amounts 0 .. 2^AMT_W-1
// PORTS
//  clock       in   1       rising-edge clock
//  reset       in   1       asynchronous, active-low reset
//  load        in   1       parallel load strobe (accepted only when not busy)
//  D           in   WIDTH   parallel load data
//  start       in   1       shift request (accepted only when not busy)
//  mode        in   2       00 LSL, 01 LSR, 10 ASR, 11 ROL (see CONFIGURATION)
//  amount      in   AMT_W   shift count, sampled on the start edge
//  Q           out  WIDTH   register contents
//  serial_out  out  1       bit shifted out on the most recent shift cycle
//  busy        out  1       high while shifting
//  done        out  1       one-cycle pulse when a requested shift completes
// BEHAVIOUR
//  - Reset low: Q=0, serial_out=0, busy=0, done=0, state=IDLE, count=0.
//    Takes effect immediately, including mid-shift; an interrupted shift is discarded.
//  - States IDLE, SHIFT, DONE. mode and amount are latched on the start edge;
//    later changes do not affect the operation in progress.
//  - Priority: when IDLE or DONE, load wins over start in the same cycle. Q<=D and
//    the start is dropped (no busy, no done).
//  - Start accepted with amount=0: next state DONE. Q unchanged, done=1 for one cycle.
//  - Start accepted with amount=N>0: next state SHIFT, count=N. Each SHIFT cycle:
//    * one 1-bit shift of Q, count decrements;
//    * on the edge where count reaches 0, the next state is DONE.
//    * busy is high for exactly N cycles; final Q is visible with done=1 in the cycle
//      after the N-th shift; DONE lasts one cycle, then IDLE.
//  - Shift ops per cycle:
//    * LSL: Q<={Q[W-2:0],0}, serial_out<=Q[W-1]
//    * LSR: Q<={0,Q[W-1:1]}, serial_out<=Q[0]
//    * ASR: Q<={Q[W-1],Q[W-1:1]}, serial_out<=Q[0]
//  - Amounts >= WIDTH are not clamped. Latency is still amount cycles.
//    Result: LSL/LSR give 0; ASR gives all copies of the sign bit.
//  - Back-to-back: start (or load) is accepted in the DONE cycle. A start in DONE
//    enters SHIFT/DONE next cycle with no IDLE gap.
//  - load and start while busy=1 are ignored; no queuing.
//  - serial_out holds its value outside SHIFT cycles. It is not updated by load.
// CONFIGURATION
//  SHIFTREG_ROTATE_EN defined:
//    mode 11 = rotate left: Q<={Q[W-2:0],Q[W-1]}, serial_out<=Q[W-1].
//  SHIFTREG_ROTATE_EN undefined:
//    mode 11 executes exactly as LSL; no rotate logic is synthesised.
// TESTING
//  1 load D=1, start LSL amount=4 -> busy high 4 cycles, then Q=128'h10, done=1 for
//    one cycle, serial_out=0.
//  2 load D=128'h8000...0000, start ASR amount=3 -> Q=128'hF000...0000, serial_out=0.
//    Same data with LSR -> Q=128'h1000...0000.
//  3 start LSR amount=0 with Q=128'hA5 -> no busy, done pulses the next cycle,
//    Q stays 128'hA5.
//  4 load and start together in IDLE -> Q=D, busy=0, done never asserts.
//    While busy, pulse start and load with new D -> both ignored; result unchanged.
//  5 drive reset low mid-shift (count=2 of 5) -> Q=0, busy=0, done=0 immediately,
//    before any clock edge. Release -> IDLE; the next start behaves normally.
//  6 load 128'h8000...0001, start mode=11 amount=1 -> 128'h...0003 with
//    SHIFTREG_ROTATE_EN; 128'h...0002 without it. Both give serial_out=1.

Source files
------------

// File: rtl/shift_register_universal_if.sv
// Bus interface for shift_register_universal: load/start handshake,
// mode and amount request, and the register/status outputs.
// The master side issues requests; the slave side is the shifter.
interface shift_register_universal_if #(
    parameter int WIDTH = 128,
    parameter int AMT_W = 8
);
    logic             load;
    logic [WIDTH-1:0] D;
    logic             start;
    logic [1:0]       mode;
    logic [AMT_W-1:0] amount;
    logic [WIDTH-1:0] Q;
    logic             serial_out;
    logic             busy;
    logic             done;

    modport master (
        output load, D, start, mode, amount,
        input  Q, serial_out, busy, done
    );

    modport slave (
        input  load, D, start, mode, amount,
        output Q, serial_out, busy, done
    );
endinterface

// File: rtl/shift_register_universal.sv
// Multi-mode sequential shift register: parallel load, then a multi-cycle
// shift of the requested amount, one bit per clock, with busy/done status.
// Modes: 00 LSL, 01 LSR, 10 ASR, 11 ROL when SHIFTREG_ROTATE_EN is defined,
// otherwise mode 11 behaves exactly as LSL and no rotate path exists.
// Reset is asynchronous and active-low.
module shift_register_universal #(
    parameter int WIDTH = 128,
    parameter int AMT_W = 8
) (
    input logic clock,
    input logic reset,
    shift_register_universal_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           nextState;
    logic [AMT_W-1:0] count;
    logic [1:0]       opMode;
    logic [WIDTH-1:0] qReg;
    logic             serialReg;
    logic [WIDTH-1:0] shiftedQ;
    logic             shiftedBit;
    logic             accepting;
    logic             loadTaken;
    logic             startTaken;

    // Requests are only honoured outside SHIFT; load has priority over start.
    assign accepting  = (state != SHIFT);
    assign loadTaken  = accepting & bus.load;
    assign startTaken = accepting & bus.start & ~bus.load;

    // State register; reset drops any shift in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic: a zero amount goes straight to DONE, otherwise SHIFT
    // runs until the last bit has been shifted.
    always_comb begin
        nextState = state;
        case (state)
            IDLE, DONE: begin
                if (loadTaken) begin
                    nextState = IDLE;
                end else if (startTaken) begin
                    nextState = (bus.amount == '0) ? DONE : SHIFT;
                end else begin
                    nextState = IDLE;
                end
            end
            SHIFT: begin
                if (count == AMT_W'(1)) begin
                    nextState = DONE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // One-bit shift of the current contents according to the latched mode.
    always_comb begin
        shiftedQ   = {qReg[WIDTH-2:0], 1'b0};
        shiftedBit = qReg[WIDTH-1];
        case (opMode)
            2'b01: begin
                shiftedQ   = {1'b0, qReg[WIDTH-1:1]};
                shiftedBit = qReg[0];
            end
            2'b10: begin
                shiftedQ   = {qReg[WIDTH-1], qReg[WIDTH-1:1]};
                shiftedBit = qReg[0];
            end
`ifdef SHIFTREG_ROTATE_EN
            2'b11: begin
                shiftedQ   = {qReg[WIDTH-2:0], qReg[WIDTH-1]};
                shiftedBit = qReg[WIDTH-1];
            end
`endif
            default: begin
                shiftedQ   = {qReg[WIDTH-2:0], 1'b0};
                shiftedBit = qReg[WIDTH-1];
            end
        endcase
    end

    // Datapath: parallel load, request latching, and per-cycle shifting.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            qReg      <= '0;
            serialReg <= 1'b0;
            count     <= '0;
            opMode    <= 2'b00;
        end else if (loadTaken) begin
            qReg <= bus.D;
        end else if (startTaken) begin
            count  <= bus.amount;
            opMode <= bus.mode;
        end else if (state == SHIFT) begin
            qReg      <= shiftedQ;
            serialReg <= shiftedBit;
            count     <= count - AMT_W'(1);
        end
    end

    assign bus.Q          = qReg;
    assign bus.serial_out = serialReg;
    assign bus.busy       = (state == SHIFT);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// Self-checking bench for shift_register_universal: directed scenarios plus
// randomized load/shift sequences checked against an arithmetic model.
module tb_shift_register_universal;

    localparam int W = 128;

    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] expQ;
    logic         expSerial;

    shift_register_universal_if #(.WIDTH(W), .AMT_W(8)) bus ();

    shift_register_universal #(.WIDTH(W), .AMT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                               input logic [W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Result of shifting q by n positions in one go.
    function automatic logic [W-1:0] modelShift(input logic [W-1:0] q,
                                                input logic [1:0] m, input int n);
        logic [W-1:0] r;
        int           k;
        case (m)
            2'b01:   r = q >> n;
            2'b10:   r = $signed(q) >>> n;
`ifdef SHIFTREG_ROTATE_EN
            2'b11: begin
                k = n % W;
                r = (k == 0) ? q : ((q << k) | (q >> (W - k)));
            end
`endif
            default: r = q << n;
        endcase
        return r;
    endfunction

    // Last bit leaving the register: the exit bit of the value one step earlier.
    function automatic logic modelSerial(input logic [W-1:0] q,
                                         input logic [1:0] m, input int n);
        logic [W-1:0] prev;
        prev = modelShift(q, m, n - 1);
        if (m == 2'b01 || m == 2'b10) return prev[0];
        return prev[W-1];
    endfunction

    // Drive one cycle of request inputs, then scramble them so latching is exercised.
    task automatic applyStimulus(input logic ld, input logic [W-1:0] data,
                                 input logic st, input logic [1:0] m, input logic [7:0] n);
        bus.load   = ld;
        bus.D      = data;
        bus.start  = st;
        bus.mode   = m;
        bus.amount = n;
        tick();
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 2'($urandom_range(0, 3));
        bus.amount = 8'($urandom_range(0, 255));
        bus.D      = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic loadData(input logic [W-1:0] data);
        applyStimulus(1'b1, data, 1'b0, 2'b00, 8'd0);
        expQ = data;
        checkOutput("load Q", bus.Q, expQ);
        checkOutput("load busy", W'(bus.busy), W'(0));
        checkOutput("load serial", W'(bus.serial_out), W'(expSerial));
    endtask

    // Start a shift from IDLE or DONE and follow it into its DONE cycle.
    task automatic runShift(input logic [1:0] m, input int n, input bit interfere);
        logic [W-1:0] startQ;
        startQ = expQ;
        applyStimulus(1'b0, '0, 1'b1, m, 8'(n));
        for (int i = 0; i < n; i++) begin
            checkOutput("busy during shift", W'(bus.busy), W'(1));
            checkOutput("done during shift", W'(bus.done), W'(0));
            if (interfere && i == 0)
                applyStimulus(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1,
                              2'($urandom_range(0, 3)), 8'd0);
            else
                tick();
        end
        expQ = modelShift(startQ, m, n);
        if (n > 0) expSerial = modelSerial(startQ, m, n);
        checkOutput("done pulse", W'(bus.done), W'(1));
        checkOutput("busy at done", W'(bus.busy), W'(0));
        checkOutput("result Q", bus.Q, expQ);
        checkOutput("result serial", W'(bus.serial_out), W'(expSerial));
    endtask

    task automatic finishIdle();
        tick();
        checkOutput("done cleared", W'(bus.done), W'(0));
        checkOutput("idle busy", W'(bus.busy), W'(0));
        checkOutput("idle Q", bus.Q, expQ);
    endtask

    initial begin
        logic [W-1:0] v;
        int           n;
        reset      = 1'b0;
        bus.load   = 1'b0;
        bus.start  = 1'b0;
        bus.D      = '0;
        bus.mode   = 2'b00;
        bus.amount = 8'd0;
        expQ       = '0;
        expSerial  = 1'b0;
        #12;
        checkOutput("reset Q", bus.Q, '0);
        checkOutput("reset busy", W'(bus.busy), W'(0));
        checkOutput("reset done", W'(bus.done), W'(0));
        checkOutput("reset serial", W'(bus.serial_out), W'(0));
        @(negedge clock);
        reset = 1'b1;
        tick();

        // LSL of 1 by 4
        loadData(W'(1));
        runShift(2'b00, 4, 1'b0);
        checkOutput("lsl4 const", bus.Q, W'(128'h10));
        finishIdle();

        // ASR and LSR of the sign bit by 3
        loadData({1'b1, 127'b0});
        runShift(2'b10, 3, 1'b0);
        checkOutput("asr3 const", bus.Q, {4'hF, 124'b0});
        finishIdle();
        loadData({1'b1, 127'b0});
        runShift(2'b01, 3, 1'b0);
        checkOutput("lsr3 const", bus.Q, {4'h1, 124'b0});
        finishIdle();

        // Zero-amount start
        loadData(W'(128'hA5));
        runShift(2'b01, 0, 1'b0);
        checkOutput("amt0 Q", bus.Q, W'(128'hA5));
        finishIdle();

        // Load and start together: load wins, start dropped
        applyStimulus(1'b1, W'(128'h1234), 1'b1, 2'b00, 8'd5);
        expQ = W'(128'h1234);
        checkOutput("ld+st Q", bus.Q, expQ);
        checkOutput("ld+st busy", W'(bus.busy), W'(0));
        for (int i = 0; i < 3; i++) finishIdle();

        // Load/start while busy are ignored
        loadData(W'(128'hF0F0));
        runShift(2'b00, 6, 1'b1);
        finishIdle();

        // Asynchronous reset mid-shift
        loadData({$urandom, $urandom, $urandom, $urandom});
        applyStimulus(1'b0, '0, 1'b1, 2'b01, 8'd5);
        tick();
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        expQ = '0;
        expSerial = 1'b0;
        checkOutput("midreset Q", bus.Q, '0);
        checkOutput("midreset busy", W'(bus.busy), W'(0));
        checkOutput("midreset done", W'(bus.done), W'(0));
        checkOutput("midreset serial", W'(bus.serial_out), W'(0));
        @(negedge clock);
        reset = 1'b1;
        finishIdle();
        loadData(W'(128'h9));
        runShift(2'b01, 2, 1'b0);
        finishIdle();

        // Mode 11: rotate when enabled, LSL otherwise
        loadData({1'b1, 126'b0, 1'b1});
`ifdef SHIFTREG_ROTATE_EN
        runShift(2'b11, 1, 1'b0);
        checkOutput("mode11 const", bus.Q, W'(128'h3));
`else
        runShift(2'b11, 1, 1'b0);
        checkOutput("mode11 const", bus.Q, W'(128'h2));
`endif
        checkOutput("mode11 serial", W'(bus.serial_out), W'(1));
        finishIdle();

        // Back-to-back start in the DONE cycle
        loadData(W'(128'hC3));
        runShift(2'b00, 2, 1'b0);
        runShift(2'b01, 3, 1'b0);
        runShift(2'b10, 0, 1'b0);
        finishIdle();

        // Randomized sequences
        for (int it = 0; it < 40; it++) begin
            v = {$urandom, $urandom, $urandom, $urandom};
            loadData(v);
            n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                            : int'($urandom_range(0, 20));
            runShift(2'($urandom_range(0, 3)), n, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1)
                runShift(2'($urandom_range(0, 3)), int'($urandom_range(0, 12)), 1'b0);
            if ($urandom_range(0, 1) == 1) finishIdle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
